// File: rtl/clk_gate_ctrl.sv
// Enable-side controller for a clk_gater_ul cell: idle detection, drain handshake, gate-off and timed wake-up.
// Optional gated-cycle statistics counter is built when CLK_GATE_STATS_EN is defined.
module clk_gate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
`ifdef CLK_GATE_STATS_EN
    , parameter int STATS_WIDTH = 32
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic activity_i,
    input  logic wakeReq_i,
    input  logic drainAck_i,
    output logic clkEn_o,
    output logic drainReq_o,
    output logic ready_o,
    output logic gated_o
`ifdef CLK_GATE_STATS_EN
    , output logic [STATS_WIDTH-1:0] gatedCycles_o
`endif
);

    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [7:0]    WAKE_LAST = 8'(WAKE_CYCLES - 1);

    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_GATED  = 2'd2;
    localparam logic [1:0] ST_WAKE   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [7:0]    wake_q, wake_d;
    logic          clk_en_q, ready_q, drain_q, gated_q;
    logic          wake_evt;

    assign wake_evt = activity_i | wakeReq_i;

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        wake_d  = wake_q;
        case (state_q)
            ST_ACTIVE: begin
                if (wake_evt) begin
                    idle_d = '0;
                end else if (idle_q == IDLE_LAST) begin
                    state_d = ST_DRAIN;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
            end
            ST_DRAIN: begin
                // An abort wins over a simultaneous acknowledge.
                if (wake_evt) begin
                    state_d = ST_ACTIVE;
                end else if (drainAck_i) begin
                    state_d = ST_GATED;
                end
            end
            ST_GATED: begin
                if (wake_evt) begin
                    state_d = ST_WAKE;
                    wake_d  = '0;
                end
            end
            ST_WAKE: begin
                wake_d = wake_q + 8'd1;
                if (wake_q == WAKE_LAST) begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d = ST_ACTIVE;
                idle_d  = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_ACTIVE;
            idle_q   <= '0;
            wake_q   <= '0;
            clk_en_q <= 1'b1;
            ready_q  <= 1'b1;
            drain_q  <= 1'b0;
            gated_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idle_q   <= idle_d;
            wake_q   <= wake_d;
            clk_en_q <= (state_d != ST_GATED);
            ready_q  <= (state_d == ST_ACTIVE);
            drain_q  <= (state_d == ST_DRAIN);
            gated_q  <= (state_d == ST_GATED);
        end
    end

    assign clkEn_o    = clk_en_q;
    assign ready_o    = ready_q;
    assign drainReq_o = drain_q;
    assign gated_o    = gated_q;

`ifdef CLK_GATE_STATS_EN
    logic [STATS_WIDTH-1:0] stats_q, stats_d;

    always_comb begin
        stats_d = stats_q;
        if (state_q == ST_GATED && stats_q != {STATS_WIDTH{1'b1}}) begin
            stats_d = stats_q + STATS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stats_q <= '0;
        end else begin
            stats_q <= stats_d;
        end
    end

    assign gatedCycles_o = stats_q;
`endif

endmodule
